mem_align_unit: RTL and testbench

//  Load/store front end between the pipeline MEM stage and the data port (port 2) of the OTTER dual-port memory.

---
 rtl/mem_align_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_align_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_align_unit.sv
// Load/store front end for the OTTER data port: splits word-spanning accesses into
// aligned reads or byte writes, and merges, slices and extends load data itself.
module mem_align_unit #(
   parameter logic [31:0] IO_BASE   = 32'h1100_0000,
   parameter logic [31:0] MEM_BYTES = 32'd65536
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [31:0] REQ_ADDR,
   input  logic        REQ_WE,
   input  logic [1:0]  REQ_SIZE,
   input  logic        REQ_SIGN,
   input  logic [31:0] REQ_WDATA,
   output logic        RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_WRITE2,
   output logic        MEM_READ2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT2
);

   typedef enum logic [2:0] {StIdle, StLdA, StLdB, StLdC, StStW, StStB, StResp} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_addr, w_addr_nxt, r_wdata, w_wdata_nxt;
   logic [31:0] r_lo, w_lo_nxt, r_hi, w_hi_nxt;
   logic [1:0]  r_size, w_size_nxt, r_k, w_k_nxt;
   logic        r_we, w_we_nxt, r_sign, w_sign_nxt, r_err, w_err_nxt;

   logic [2:0]  w_req_len, w_len;
   logic [31:0] w_req_last, w_base, w_pair, w_load;
   logic [1:0]  w_last_k;
   logic        w_req_err, w_req_span, w_span;
   logic [7:0]  w_byte;

   function automatic logic [2:0] size_len(input logic [1:0] size);
      case (size)
         2'd0:    size_len = 3'd1;
         2'd1:    size_len = 3'd2;
         default: size_len = 3'd4;
      endcase
   endfunction

   assign w_req_len  = size_len(REQ_SIZE);
   assign w_req_last = REQ_ADDR + {29'd0, w_req_len} - 32'd1;
   assign w_req_span = ({1'b0, REQ_ADDR[1:0]} + w_req_len) > 3'd4;
   // The tail check only matters when RAM ends right below the MMIO window.
   assign w_req_err  = (REQ_SIZE == 2'd3)
                     | (REQ_ADDR >= MEM_BYTES && REQ_ADDR < IO_BASE)
                     | (REQ_ADDR < IO_BASE && w_req_last >= IO_BASE)
                     | (REQ_ADDR >= IO_BASE && (REQ_SIZE != 2'd2 || REQ_ADDR[1:0] != 2'd0));

   assign w_len    = size_len(r_size);
   assign w_span   = ({1'b0, r_addr[1:0]} + w_len) > 3'd4;
   assign w_last_k = 2'(w_len - 3'd1);
   assign w_base   = {r_addr[31:2], 2'b00};
   assign w_pair   = 32'({r_hi, r_lo} >> {r_addr[1:0], 3'b000});
   assign w_byte   = r_wdata[{r_k, 3'b000} +: 8];
   assign MEM_SIGN = 1'b0;

   always_comb begin
      case (r_size)
         2'd0:    w_load = {{24{r_sign & w_pair[7]}}, w_pair[7:0]};
         2'd1:    w_load = {{16{r_sign & w_pair[15]}}, w_pair[15:0]};
         default: w_load = w_pair;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= StIdle;
         r_addr  <= '0;
         r_wdata <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_size  <= '0;
         r_k     <= '0;
         r_we    <= 1'b0;
         r_sign  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_lo    <= w_lo_nxt;
         r_hi    <= w_hi_nxt;
         r_size  <= w_size_nxt;
         r_k     <= w_k_nxt;
         r_we    <= w_we_nxt;
         r_sign  <= w_sign_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_lo_nxt    = r_lo;
      w_hi_nxt    = r_hi;
      w_size_nxt  = r_size;
      w_k_nxt     = r_k;
      w_we_nxt    = r_we;
      w_sign_nxt  = r_sign;
      w_err_nxt   = r_err;
      REQ_READY   = 1'b0;
      RSP_VALID   = 1'b0;
      RSP_RDATA   = '0;
      RSP_ERR     = 1'b0;
      MEM_ADDR2   = '0;
      MEM_DIN2    = '0;
      MEM_WRITE2  = 1'b0;
      MEM_READ2   = 1'b0;
      MEM_SIZE    = 2'd0;
      unique case (r_state)
         StIdle: begin
            REQ_READY = RST_N;
            if (REQ_VALID) begin
               w_addr_nxt  = REQ_ADDR;
               w_wdata_nxt = REQ_WDATA;
               w_size_nxt  = REQ_SIZE;
               w_we_nxt    = REQ_WE;
               w_sign_nxt  = REQ_SIGN;
               w_err_nxt   = w_req_err;
               w_lo_nxt    = '0;
               w_hi_nxt    = '0;
               w_k_nxt     = 2'd0;
               if (w_req_err)       w_state_nxt = StResp;
               else if (!REQ_WE)    w_state_nxt = StLdA;
               else if (w_req_span) w_state_nxt = StStB;
               else                 w_state_nxt = StStW;
            end
         end
         StLdA: begin
            MEM_READ2   = 1'b1;
            MEM_ADDR2   = w_base;
            MEM_SIZE    = 2'd2;
            w_state_nxt = StLdB;
         end
         StLdB: begin
            w_lo_nxt = MEM_DOUT2;
            if (w_span) begin
               MEM_READ2   = 1'b1;
               MEM_ADDR2   = w_base + 32'd4;
               MEM_SIZE    = 2'd2;
               w_state_nxt = StLdC;
            end else begin
               w_state_nxt = StResp;
            end
         end
         StLdC: begin
            w_hi_nxt    = MEM_DOUT2;
            w_state_nxt = StResp;
         end
         StStW: begin
            MEM_WRITE2  = 1'b1;
            MEM_ADDR2   = r_addr;
            MEM_SIZE    = r_size;
            MEM_DIN2    = r_wdata;
            w_state_nxt = StResp;
         end
         StStB: begin
            // One byte per cycle, lowest address first.
            MEM_WRITE2 = 1'b1;
            MEM_ADDR2  = r_addr + {30'd0, r_k};
            MEM_DIN2   = {24'h0, w_byte};
            if (r_k == w_last_k) w_state_nxt = StResp;
            else                 w_k_nxt     = r_k + 2'd1;
         end
         StResp: begin
            RSP_VALID   = 1'b1;
            RSP_ERR     = r_err;
            RSP_RDATA   = (r_err || r_we) ? 32'h0 : w_load;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit against a byte-addressed memory model with a
// one-cycle read latency and a fixed MMIO read value.
module tb_mem_align_unit;

   localparam logic [31:0] IoBase = 32'h1100_0000;
   localparam logic [31:0] MmioRd = 32'h1234_5678;

   logic        CLK = 1'b0, RST_N = 1'b0;
   logic        REQ_VALID = 1'b0, REQ_WE = 1'b0, REQ_SIGN = 1'b0;
   logic [31:0] REQ_ADDR = '0, REQ_WDATA = '0;
   logic [1:0]  REQ_SIZE = '0;
   logic        REQ_READY, RSP_VALID, RSP_ERR, MEM_WRITE2, MEM_READ2, MEM_SIGN;
   logic [31:0] RSP_RDATA, MEM_ADDR2, MEM_DIN2;
   logic [1:0]  MEM_SIZE;
   logic [31:0] MEM_DOUT2 = '0;

   logic [7:0]  mem [0:65535];
   int          checks = 0, errors = 0;

   mem_align_unit dut (
      .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_ADDR(REQ_ADDR), .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
      .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
      .RSP_ERR(RSP_ERR), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
      .MEM_WRITE2(MEM_WRITE2), .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE),
      .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rd_word(input logic [31:0] ad);
      logic [15:0] a;
      a = ad[15:0];
      if (ad >= IoBase) return MmioRd;
      return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
   endfunction

   // Memory model: sole writer of mem, read data registered one cycle.
   initial begin
      logic [15:0] a;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h100] = 8'hEF; mem[16'h101] = 8'hBE; mem[16'h102] = 8'hAD; mem[16'h103] = 8'hDE;
      forever begin
         @(posedge CLK);
         if (MEM_READ2) MEM_DOUT2 <= rd_word(MEM_ADDR2);
         if (MEM_WRITE2 && MEM_ADDR2 < IoBase) begin
            a = MEM_ADDR2[15:0];
            mem[a] = MEM_DIN2[7:0];
            if (MEM_SIZE != 2'd0) mem[a + 16'd1] = MEM_DIN2[15:8];
            if (MEM_SIZE == 2'd2) begin
               mem[a + 16'd2] = MEM_DIN2[23:16];
               mem[a + 16'd3] = MEM_DIN2[31:24];
            end
         end
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;   // 0: latency not checked
      int          rd;
      int          wr;
   } vec_t;

   vec_t vecs[$];

   task automatic check32(input string name, input int idx, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] addr, input logic we, input logic [1:0] size,
                      input logic sign, input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic err, input int lat, input int rd, input int wr);
      vec_t v;
      v = '{addr, we, size, sign, wdata, rdata, err, lat, rd, wr};
      vecs.push_back(v);
   endtask

   // Called at a negedge; returns at the negedge after the response.
   task automatic apply(input vec_t v, input int idx);
      int cyc, rd, wr;
      logic got, err, clash;
      logic [31:0] rdata;
      for (int i = 0; i < 20 && !REQ_READY; i++) @(negedge CLK);
      check32("ready", idx, {31'd0, REQ_READY}, 32'd1);
      REQ_ADDR = v.addr; REQ_WE = v.we; REQ_SIZE = v.size;
      REQ_SIGN = v.sign; REQ_WDATA = v.wdata; REQ_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      REQ_VALID = 1'b0;
      cyc = 0; rd = 0; wr = 0; got = 1'b0; clash = 1'b0; err = 1'b0; rdata = '0;
      while (!got && cyc < 30) begin
         cyc++;
         if (MEM_READ2) rd++;
         if (MEM_WRITE2) wr++;
         if ((MEM_READ2 && MEM_WRITE2) || MEM_SIGN) clash = 1'b1;
         if (RSP_VALID) begin
            got = 1'b1; rdata = RSP_RDATA; err = RSP_ERR;
         end else begin
            @(negedge CLK);
         end
      end
      check32("rsp_seen", idx, {31'd0, got}, 32'd1);
      check32("rdata", idx, rdata, v.rdata);
      check32("err", idx, {31'd0, err}, {31'd0, v.err});
      if (v.lat != 0) check32("latency", idx, cyc, v.lat);
      check32("reads", idx, rd, v.rd);
      check32("writes", idx, wr, v.wr);
      check32("strobe_excl", idx, {31'd0, clash}, 32'd0);
      @(negedge CLK);
      check32("ready_next", idx, {31'd0, REQ_READY}, 32'd1);
      check32("rsp_once", idx, {31'd0, RSP_VALID}, 32'd0);
   endtask

   initial begin
      logic fired;
      // addr, we, size, sign, wdata, rdata, err, lat, rd, wr
      add(32'h100, 0, 2, 0, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0);
      add(32'h100, 1, 2, 0, 32'h0,        32'h0,        0, 2, 0, 1);
      add(32'h0FE, 1, 2, 0, 32'h11223344, 32'h0,        0, 5, 0, 4);
      add(32'h0FC, 0, 2, 0, 32'h0,        32'h33440000, 0, 3, 1, 0);
      add(32'h100, 0, 2, 0, 32'h0,        32'h00001122, 0, 3, 1, 0);
      add(32'h100, 1, 2, 0, 32'hAB000000, 32'h0,        0, 2, 0, 1);
      add(32'h104, 1, 2, 0, 32'h000000CD, 32'h0,        0, 2, 0, 1);
      add(32'h103, 0, 1, 1, 32'h0,        32'hFFFFCDAB, 0, 4, 2, 0);
      add(32'h103, 0, 1, 0, 32'h0,        32'h0000CDAB, 0, 4, 2, 0);
      add(32'h103, 0, 0, 1, 32'h0,        32'hFFFFFFAB, 0, 3, 1, 0);
      add(32'h102, 0, 1, 1, 32'h0,        32'hFFFFAB00, 0, 3, 1, 0);
      add(32'h101, 0, 2, 0, 32'h0,        32'hCDAB0000, 0, 4, 2, 0);
      add(32'h103, 0, 0, 0, 32'h0,        32'h000000AB, 0, 3, 1, 0);
      add(32'h103, 1, 0, 0, 32'h0000005A, 32'h0,        0, 2, 0, 1);
      add(32'h103, 0, 0, 0, 32'h0,        32'h0000005A, 0, 3, 1, 0);
      add(32'h107, 1, 1, 0, 32'h0000BEEF, 32'h0,        0, 3, 0, 2);
      add(32'h107, 0, 1, 0, 32'h0,        32'h0000BEEF, 0, 4, 2, 0);
      add(32'h107, 0, 1, 1, 32'h0,        32'hFFFFBEEF, 0, 4, 2, 0);
      add(32'h105, 1, 0, 0, 32'hFFFFFF77, 32'h0,        0, 2, 0, 1);
      add(32'h104, 0, 2, 0, 32'h0,        32'hEF0077CD, 0, 3, 1, 0);
      add(32'h10A, 1, 1, 0, 32'h00001234, 32'h0,        0, 2, 0, 1);
      add(32'h108, 0, 2, 0, 32'h0,        32'h123400BE, 0, 3, 1, 0);
      add(32'h100, 0, 3, 0, 32'h0,        32'h0,        1, 0, 0, 0);
      add(32'h11000002, 0, 2, 0, 32'h0,   32'h0,        1, 0, 0, 0);
      add(32'h00010000, 1, 2, 0, 32'h5,   32'h0,        1, 0, 0, 0);
      add(32'h11000000, 0, 1, 0, 32'h0,   32'h0,        1, 0, 0, 0);
      add(32'h00020000, 0, 0, 0, 32'h0,   32'h0,        1, 0, 0, 0);
      add(32'h11000000, 0, 2, 0, 32'h0,   MmioRd,       0, 3, 1, 0);
      add(32'h11000004, 1, 2, 0, 32'h9,   32'h0,        0, 2, 0, 1);

      // Reset state, with a request pending to confirm READY is gated.
      REQ_VALID = 1'b1;
      repeat (2) @(negedge CLK);
      check32("rst_ready", 0, {31'd0, REQ_READY}, 32'd0);
      check32("rst_rsp", 0, {30'd0, RSP_VALID, RSP_ERR}, 32'd0);
      check32("rst_rdata", 0, RSP_RDATA, 32'd0);
      check32("rst_strobes", 0, {29'd0, MEM_READ2, MEM_WRITE2, MEM_SIGN}, 32'd0);
      check32("rst_addr", 0, MEM_ADDR2, 32'd0);
      check32("rst_din", 0, MEM_DIN2, 32'd0);
      check32("rst_size", 0, {30'd0, MEM_SIZE}, 32'd0);
      REQ_VALID = 1'b0;
      RST_N = 1'b1;
      @(negedge CLK);
      check32("idle_ready", 0, {31'd0, REQ_READY}, 32'd1);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Reset during the second byte of a spanning store.
      REQ_ADDR = 32'h1FE; REQ_WE = 1'b1; REQ_SIZE = 2'd2; REQ_SIGN = 1'b0;
      REQ_WDATA = 32'hAABBCCDD; REQ_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      REQ_VALID = 1'b0;
      check32("stb_k0_we", 100, {31'd0, MEM_WRITE2}, 32'd1);
      check32("stb_k0_addr", 100, MEM_ADDR2, 32'h1FE);
      check32("stb_k0_din", 100, MEM_DIN2, 32'h000000DD);
      @(negedge CLK);
      check32("stb_k1_addr", 100, MEM_ADDR2, 32'h1FF);
      check32("stb_k1_din", 100, MEM_DIN2, 32'h000000CC);
      #1 RST_N = 1'b0;
      #1;
      check32("midrst_strobes", 100, {30'd0, MEM_WRITE2, MEM_READ2}, 32'd0);
      check32("midrst_ready", 100, {31'd0, REQ_READY}, 32'd0);
      fired = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (RSP_VALID) fired = 1'b1;
      end
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (RSP_VALID) fired = 1'b1;
      end
      check32("midrst_no_rsp", 100, {31'd0, fired}, 32'd0);
      check32("midrst_idle", 100, {31'd0, REQ_READY}, 32'd1);
      check32("partial_b0", 100, {24'd0, mem[16'h1FE]}, 32'h000000DD);
      check32("partial_b1", 100, {24'd0, mem[16'h1FF]}, 32'h00000000);
      begin
         vec_t v;
         v = '{32'h1FC, 1'b0, 2'd2, 1'b0, 32'h0, 32'h00DD0000, 1'b0, 3, 1, 0};
         apply(v, 101);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
